lkahd_subtractor: RTL
=====================

# lkahd_subtractor

Sequential multi-slice subtractor computing `x - y - bin` on WIDTH-bit unsigned operands. Each clock it processes one 3-bit slice, using borrow-lookahead generate/propagate terms, and carries the slice borrow in a register. It is the subtract-side companion to the team's 3-bit lookahead adder. It sits in the datapath where a wide difference is needed and a single-cycle ripple or full lookahead is not worth the area. A start/busy/done handshake sequences it.

## Interface
Parameters:
- WIDTH, default 9: operand and result width. Must be a multiple of 3 and at least 3. Number of slices K = WIDTH/3.

Ports:
- clk, input, 1: rising-edge clock, the only clock.
- rst_n, input, 1: reset, synchronous, active-low.
- start, input, 1: request. Sampled only in IDLE.
- x, input, WIDTH: minuend. Captured on the accepting edge.
- y, input, WIDTH: subtrahend. Captured on the accepting edge.
- bin, input, 1: borrow-in. Captured on the accepting edge.
- busy, output, 1: high while in RUN.
- done, output, 1: one-cycle completion pulse (DONE state).
- diff, output, WIDTH: registered result, `(x - y - bin) mod 2^WIDTH`.
- bout, output, 1: registered borrow-out. 1 iff x < y + bin (unsigned).

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN: on an edge with start=1.
  - Latch x, y, bin into operand registers.
  - Slice index k = 0.
  - Borrow register b = bin.
- RUN, each edge, for slice k (bits 3k+2..3k):
  - Per bit: g_i = ~x_i & y_i, p_i = ~(x_i ^ y_i).
  - Internal borrows, lookahead form, not rippled:
    - b1 = g0 | p0&b
    - b2 = g1 | p1&g0 | p1&p0&b
    - bnext = g2 | p2&g1 | p2&p1&g0 | p2&p1&p0&b
  - Difference bits: d_i = x_i ^ y_i ^ b_i, with b_0 = b.
  - Store d into internal result bits 3k+2..3k. Set b <= bnext. Set k <= k+1.
- RUN -> DONE: on the edge that processes slice k = K-1.
  - On that same edge, diff <= full internal result and bout <= bnext.
- DONE -> IDLE: unconditionally on the next edge.
- start:
  - Ignored in RUN and DONE. A new request can be accepted one cycle after done.
  - x, y, bin may change freely after the accepting edge.
- diff and bout:
  - Change only on the final RUN edge.
  - Hold their value through IDLE until the next completion. Partial results are never visible.
- Reset (rst_n=0 at an edge), from any state including mid-RUN:
  - State goes to IDLE.
  - busy=0, done=0, diff=0, bout=0, k=0, b=0.
  - The operation is aborted and no done pulse is produced.
- If rst_n=0 and start=1 on the same edge, reset wins.

## Timing
- Edge numbering: start is accepted at edge 0.
- busy is high from after edge 0 until edge K.
- done is high for exactly one cycle, from edge K to edge K+1. diff and bout are valid from edge K.
- Latency is K cycles from acceptance to done. Issue interval is K+1 cycles minimum (K+2 including the IDLE cycle in which start is sampled).
- For WIDTH=9: done asserts 3 cycles after acceptance.
- Reset values of all outputs are 0. The first cycle after reset release is IDLE.
- The combinational path per cycle is one 3-bit lookahead slice only. There is no WIDTH-long ripple path.

## Test plan
All cases use WIDTH=9.
- Basic: x=300, y=45, bin=0, start pulse -> busy high for 3 cycles, then done for 1 cycle, with diff=255 and bout=0.
- Underflow: x=0, y=1, bin=0 -> diff=511, bout=1. Also x=511, y=511, bin=1 -> diff=511, bout=1.
- Cross-slice borrow and zero: x=8, y=1, bin=0 -> diff=7, bout=0. Also x=100, y=100, bin=0 -> diff=0, bout=0.
- Handshake:
  - Start held high continuously with x=20, y=5 -> first result diff=15.
  - Operands changed to x=9, y=9 during RUN -> no effect on the in-flight result.
  - The next accept occurs only in IDLE, giving diff=0 K+2 cycles later.
  - done is never high for 2 consecutive cycles.
- Reset mid-operation: accept x=300, y=45, then assert rst_n=0 after edge 1 -> next edge gives busy=0, done=0, diff=0, bout=0. No done pulse follows. A fresh start with x=10, y=3, bin=1 -> diff=6.
- Random: 1000 random x, y, bin -> diff and bout match the reference `x - y - bin` (10-bit result split into borrow and 9-bit difference), with latency exactly 3 cycles each time.

Source files
------------

// File: rtl/lkahd_subtractor.sv
// lkahd_subtractor
//   Sequential multi-slice subtractor computing (x - y - bin) mod 2^WIDTH.
//   One 3-bit slice is resolved per clock with borrow-lookahead terms; the
//   slice borrow is carried between cycles in a register, so the only
//   combinational path per cycle is a single 3-bit lookahead slice.
//
// Parameters
//   WIDTH : operand/result width, multiple of 3 and >= 3 (K = WIDTH/3 slices)
//
// Ports
//   clk   in   rising-edge clock
//   rst_n in   synchronous active-low reset
//   start in   request, sampled only in IDLE
//   x     in   minuend, captured on the accepting edge
//   y     in   subtrahend, captured on the accepting edge
//   bin   in   borrow-in, captured on the accepting edge
//   busy  out  high while slices are being processed
//   done  out  one-cycle completion pulse
//   diff  out  registered difference, updated only on completion
//   bout  out  registered borrow-out, 1 iff x < y + bin
module lkahd_subtractor #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int K  = WIDTH / 3;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int IW = $clog2(WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One 3-bit borrow-lookahead slice: returns {borrow_out, difference}.
  // Every internal borrow is a flat sum of products of the slice inputs.
  function automatic logic [3:0] slice_sub(input logic [2:0] xs,
                                           input logic [2:0] ys,
                                           input logic       bi);
    logic [2:0] g;
    logic [2:0] p;
    logic       b1;
    logic       b2;
    logic       b3;
    g  = ~xs & ys;
    p  = ~(xs ^ ys);
    b1 = g[0] | (p[0] & bi);
    b2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    b3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
    return {b3, xs ^ ys ^ {b2, b1, bi}};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [KW-1:0]    k_q, k_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic [IW-1:0]    base_s;
  logic [3:0]       slice_s;

  // Current slice: bit offset 3k and its lookahead result.
  always_comb begin
    base_s  = IW'(k_q) * IW'(3);
    slice_s = slice_sub(x_q[base_s +: 3], y_q[base_s +: 3], b_q);
  end

  // Next-state, datapath and output-register computation.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    k_d     = k_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          x_d     = x;
          y_d     = y;
          b_d     = bin;
          k_d     = {KW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        res_d[base_s +: 3] = slice_s[2:0];
        b_d                = slice_s[3];
        if (k_q == K_LAST) begin
          // Publish the whole result at once so partial sums never show.
          state_d = ST_DONE;
          diff_d  = res_d;
          bout_d  = slice_s[3];
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= {WIDTH{1'b0}};
      y_q     <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      k_q     <= {KW{1'b0}};
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= {WIDTH{1'b0}};
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      k_q     <= k_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule
